stream_flush_initiator: RTL and testbench

Upstream end of a flushable valid/ready stream. Sources data into a chain of flushable spill-register stages through a one-entry output register, and generates the `flush_o` signal that drives their flush inputs. On a flush request it discards its own held entry, holds `flush_o` for `Depth` cycles, then acknowledges completion. It guarantees that `flush_o` and `valid_o` are never high in the same cycle, which is the downstream stages' required precondition.

---
 rtl/stream_flush_initiator.sv | 177 +++++++++++++++++
 tb/tb_stream_flush_initiator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_flush_initiator.sv
// stream_flush_initiator
//
// Upstream end of a flushable valid/ready stream. Data from the upstream
// port goes into a one-entry output register that feeds a chain of
// flushable spill-register stages. The block also generates the flush
// signal for those stages. On a flush request it discards its own held
// entry and raises flush_o for Depth cycles. It then pulses flush_ack_o
// for one cycle.
//
// flush_o and valid_o are never high together, because the downstream
// stages depend on that.
//
// Parameters
//   T      payload type
//   Depth  number of downstream flushable stages (>= 1); this is the
//          number of cycles flush_o is held
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   flush_req_i  flush request, only sampled in IDLE
//   flush_ack_o  one-cycle pulse when a flush completes
//   busy_o       high while a flush is in progress (FLUSH and DONE)
//   valid_i      upstream valid
//   ready_o      upstream ready (combinational from ready_i, flush_req_i)
//   data_i       upstream payload
//   valid_o      downstream valid (registered)
//   ready_i      downstream ready
//   data_o       downstream payload (registered)
//   flush_o      flush to the downstream stages
module stream_flush_initiator #(
    parameter type T     = logic,
    parameter int  Depth = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic flush_req_i,
    output logic flush_ack_o,
    output logic busy_o,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o,
    output logic flush_o
);

    if (Depth < 1) begin : g_depth_check
        $error("stream_flush_initiator: Depth must be >= 1");
    end

    localparam int CntW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(Depth - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_r;
    state_e          state_s;
    logic            full_r;
    T                data_r;
    logic [CntW-1:0] cnt_r;
    logic            ready_s;
    logic            load_s;
    logic            drain_s;

    // The entry register drives the downstream port directly, so there is no input-to-output path.
    assign valid_o = full_r;
    assign data_o  = data_r;
    assign ready_o = ready_s;
    assign load_s  = valid_i && ready_s;
    assign drain_s = full_r && ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. A request is only sampled in IDLE; any request in FLUSH/DONE is merged into the current flush.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_r == '0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode. Ready is only offered in IDLE with no request pending, so a request cycle never accepts an item.
    always_comb begin
        ready_s     = 1'b0;
        flush_o     = 1'b0;
        flush_ack_o = 1'b0;
        busy_o      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ready_s = !rst_i && !flush_req_i && (!full_r || ready_i);
            end
            ST_FLUSH: begin
                flush_o = 1'b1;
                busy_o  = 1'b1;
            end
            ST_DONE: begin
                flush_ack_o = 1'b1;
                busy_o      = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    // Entry register and flush hold counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_r <= 1'b0;
            data_r <= '0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Load takes priority over drain, so a simultaneous load and drain replaces the entry.
                    // A request clears the entry whether or not it is drained in the same cycle, so FLUSH always starts empty.
                    if (load_s) begin
                        data_r <= data_i;
                        full_r <= 1'b1;
                    end else if (flush_req_i || drain_s) begin
                        full_r <= 1'b0;
                    end else begin
                        full_r <= full_r;
                    end
                    if (flush_req_i) begin
                        cnt_r <= CntInit;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_FLUSH: begin
                    full_r <= 1'b0;
                    if (cnt_r != '0) begin
                        cnt_r <= cnt_r - CntW'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_DONE: begin
                    full_r <= 1'b0;
                end
                default: begin
                    full_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_flush_initiator.sv
// Self-checking bench for stream_flush_initiator. Four instances (Depth 1..4,
// T = logic [7:0]) all receive the same stimulus. Each step checks one chosen
// instance. A table of per-cycle vectors covers streaming, backpressure,
// flushing with a held entry and a held request. Hand-written sequences cover
// concurrent events and reset during a flush. A data scoreboard on the
// Depth=2 instance records items when they are accepted and compares them
// when they are delivered.
module tb_stream_flush_initiator;

    logic       clk = 1'b0;
    logic       rst;
    logic       freq;
    logic       vin;
    logic       rin;
    logic [7:0] din;

    logic       rdy_a  [1:4];
    logic       vld_a  [1:4];
    logic       fl_a   [1:4];
    logic       ack_a  [1:4];
    logic       busy_a [1:4];
    logic [7:0] dat_a  [1:4];

    int         n_chk  = 0;
    int         n_pass = 0;
    bit         sb_on  = 1'b0;
    logic [7:0] sbq[$];

    typedef struct {
        bit         sb;
        int         inst;
        logic       rst;
        logic       freq;
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       er;
        logic       ev;
        logic       ef;
        logic       ea;
        logic       eb;
        bit         cd;
        logic [7:0] ed;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        stream_flush_initiator #(.T(logic [7:0]), .Depth(g)) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .flush_req_i (freq),
            .flush_ack_o (ack_a[g]),
            .busy_o      (busy_a[g]),
            .valid_i     (vin),
            .ready_o     (rdy_a[g]),
            .data_i      (din),
            .valid_o     (vld_a[g]),
            .ready_i     (rin),
            .data_o      (dat_a[g]),
            .flush_o     (fl_a[g])
        );
    end

    task automatic report(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic got, input logic exp);
        report(name, 32'(got), 32'(exp));
    endtask

    task automatic chk_d(input string name, input logic [7:0] got, input logic [7:0] exp);
        report(name, 32'(got), 32'(exp));
    endtask

    task automatic chk_out(input int i, input string tag, input logic er, input logic ev,
                           input logic ef, input logic ea, input logic eb);
        chk_b({tag, ".ready_o"}, rdy_a[i], er);
        chk_b({tag, ".valid_o"}, vld_a[i], ev);
        chk_b({tag, ".flush_o"}, fl_a[i], ef);
        chk_b({tag, ".flush_ack_o"}, ack_a[i], ea);
        chk_b({tag, ".busy_o"}, busy_a[i], eb);
    endtask

    // Drive one cycle's inputs at the falling edge, then sample 1 ns later (well before the rising edge).
    task automatic apply(input logic r_, input logic f_, input logic v_, input logic [7:0] d_,
                         input logic rd_, input bit inv);
        @(negedge clk);
        rst  = r_;
        freq = f_;
        vin  = v_;
        din  = d_;
        rin  = rd_;
        #1;
        if (inv) begin
            for (int i = 1; i <= 4; i++) begin
                chk_b($sformatf("inv_flush_valid[%0d]", i), fl_a[i] && vld_a[i], 1'b0);
                chk_b($sformatf("inv_flush_ready[%0d]", i), fl_a[i] && rdy_a[i], 1'b0);
            end
        end
        if (sb_on) begin
            if (vld_a[2] && rin) begin
                if (sbq.size() == 0) begin
                    n_chk++;
                    $display("FAIL sb_unexpected at %0t: got item %0h, expected none", $time, dat_a[2]);
                end else begin
                    chk_d("sb_data", dat_a[2], sbq.pop_front());
                end
            end
            if (vin && rdy_a[2]) begin
                sbq.push_back(din);
            end
        end
    endtask

    task automatic do_reset();
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            chk_out(i, $sformatf("reset[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_d($sformatf("reset[%0d].data_o", i), dat_a[i], 8'h00);
        end
        sbq.delete();
    endtask

    task automatic add(input bit sb, input int inst, input logic r_, input logic f_, input logic v_,
                       input logic [7:0] d_, input logic rd_, input logic er, input logic ev,
                       input logic ef, input logic ea, input logic eb, input bit cd,
                       input logic [7:0] ed);
        vec_t t;
        t.sb = sb; t.inst = inst; t.rst = r_; t.freq = f_; t.v = v_; t.d = d_; t.r = rd_;
        t.er = er; t.ev = ev; t.ef = ef; t.ea = ea; t.eb = eb; t.cd = cd; t.ed = ed;
        tbl.push_back(t);
    endtask

    initial begin
        rst  = 1'b1;
        freq = 1'b0;
        vin  = 1'b0;
        din  = 8'h00;
        rin  = 1'b0;

        // Streaming on Depth=2: 0x01..0x08 back to back, ready_i held high.
        add(1'b1, 2, 0, 0, 1, 8'h01, 1,  1, 0, 0, 0, 0,  1'b1, 8'h00);
        for (int k = 1; k < 8; k++) begin
            add(1'b1, 2, 0, 0, 1, 8'(k + 1), 1,  1, 1, 0, 0, 0,  1'b0, 8'h00);
        end
        add(1'b1, 2, 0, 0, 0, 8'h00, 1,  1, 1, 0, 0, 0,  1'b0, 8'h00);
        add(1'b1, 2, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        // Backpressure: 0xAA held for 5 cycles while 0xBB waits.
        add(1'b1, 2, 0, 0, 1, 8'hAA, 0,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        for (int k = 0; k < 5; k++) begin
            add(1'b1, 2, 0, 0, 1, 8'hBB, 0,  0, 1, 0, 0, 0,  1'b1, 8'hAA);
        end
        add(1'b1, 2, 0, 0, 1, 8'hBB, 1,  1, 1, 0, 0, 0,  1'b1, 8'hAA);
        add(1'b1, 2, 0, 0, 0, 8'h00, 1,  1, 1, 0, 0, 0,  1'b1, 8'hBB);
        add(1'b1, 2, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        // Flush with held entry on Depth=3: request at the third row.
        add(1'b0, 3, 0, 0, 1, 8'h55, 0,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        add(1'b0, 3, 0, 0, 0, 8'h00, 0,  0, 1, 0, 0, 0,  1'b1, 8'h55);
        add(1'b0, 3, 0, 1, 1, 8'h66, 0,  0, 1, 0, 0, 0,  1'b1, 8'h55);
        for (int k = 0; k < 3; k++) begin
            add(1'b0, 3, 0, 0, 1, 8'h66, 0,  0, 0, 1, 0, 1,  1'b0, 8'h00);
        end
        add(1'b0, 3, 0, 0, 1, 8'h66, 0,  0, 0, 0, 1, 1,  1'b0, 8'h00);
        add(1'b0, 3, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        add(1'b0, 3, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0,  1'b0, 8'h00);
        // Held request on Depth=1: flush_o 1,0,0,1,0,0 and ack twice.
        add(1'b0, 1, 0, 1, 1, 8'hE0, 1,  0, 0, 0, 0, 0,  1'b0, 8'h00);
        add(1'b0, 1, 0, 1, 1, 8'hE1, 1,  0, 0, 1, 0, 1,  1'b0, 8'h00);
        add(1'b0, 1, 0, 1, 1, 8'hE2, 1,  0, 0, 0, 1, 1,  1'b0, 8'h00);
        add(1'b0, 1, 0, 1, 1, 8'hE3, 1,  0, 0, 0, 0, 0,  1'b0, 8'h00);
        add(1'b0, 1, 0, 1, 1, 8'hE4, 1,  0, 0, 1, 0, 1,  1'b0, 8'h00);
        add(1'b0, 1, 0, 1, 1, 8'hE5, 1,  0, 0, 0, 1, 1,  1'b0, 8'h00);
        add(1'b0, 1, 0, 0, 0, 8'h00, 1,  1, 0, 0, 0, 0,  1'b0, 8'h00);

        do_reset();
        foreach (tbl[i]) begin
            sb_on = tbl[i].sb;
            apply(tbl[i].rst, tbl[i].freq, tbl[i].v, tbl[i].d, tbl[i].r, 1'b1);
            chk_out(tbl[i].inst, $sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ef,
                    tbl[i].ea, tbl[i].eb);
            if (tbl[i].cd) begin
                chk_d($sformatf("vec%0d.data_o", i), dat_a[tbl[i].inst], tbl[i].ed);
            end
        end
        sb_on = 1'b0;
        report("sb_empty_stream", 32'(sbq.size()), 32'd0);

        // Concurrent events on Depth=2: request while an item drains; pulses during FLUSH/DONE.
        do_reset();
        sb_on = 1'b1;
        apply(1'b0, 1'b0, 1'b1, 8'hC1, 1'b1, 1'b1);
        chk_out(2, "conc0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1);
        chk_out(2, "conc_t", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_d("conc_t.data_o", dat_a[2], 8'hC1);
        apply(1'b0, 1'b0, 1'b1, 8'hC2, 1'b1, 1'b1);
        chk_out(2, "conc_t1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1);
        chk_out(2, "conc_t2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 8'hC2, 1'b1, 1'b1);
        chk_out(2, "conc_t3", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
        chk_out(2, "conc_t4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_out(2, "conc_t5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk_d("conc_t5.data_o", dat_a[2], 8'hC3);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_out(2, "conc_t6", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        sb_on = 1'b0;
        report("sb_empty_conc", 32'(sbq.size()), 32'd0);

        // Reset during a flush on Depth=4: no ack may ever follow.
        do_reset();
        apply(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
        chk_out(4, "rstfl0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out(4, "rstfl_t", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out(4, "rstfl_t1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk_out(4, "rstfl_t2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk_out(4, "rstfl_t3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_d("rstfl_t3.data_o", dat_a[4], 8'h00);
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            chk_b($sformatf("rstfl_post%0d.flush_ack_o", k), ack_a[4], 1'b0);
            chk_b($sformatf("rstfl_post%0d.busy_o", k), busy_a[4], 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
